// File: rtl/generic_bus_responder_pkg.sv
// Shared types for the generic bus responder: word/block types,
// bus geometry constants and the latched operation kind.
package generic_bus_responder_pkg;

  localparam int WORD_SIZE         = 4;
  localparam int RAM_ADDR_SIZE     = 32;
  localparam int DCACHE_BLOCK_SIZE = 4;

  typedef logic [WORD_SIZE*8-1:0] word_t;
  typedef word_t [DCACHE_BLOCK_SIZE-1:0] block_t;

  typedef enum logic [1:0] {
    OP_RD,
    OP_WR,
    OP_WIDE
  } op_t;

endpackage

// File: rtl/generic_bus_if.sv
// Generic request/response bus between a requester and a responder.
// generic_bus modport: responder side (requests in, rdata/busy/error out).
interface generic_bus_if;
  import generic_bus_responder_pkg::*;

  logic [RAM_ADDR_SIZE-1:0]               addr;
  logic                                   ren;
  logic                                   wen;
  logic                                   wen_wide;
  word_t                                  wdata;
  logic [WORD_SIZE-1:0]                   byte_en;
  block_t                                 wdata_wide;
  logic [DCACHE_BLOCK_SIZE*WORD_SIZE-1:0] byte_en_wide;
  word_t                                  rdata;
  block_t                                 rdata_wide;
  logic                                   busy;
  logic                                   error;

  modport generic_bus (
    input  addr, ren, wen, wen_wide,
    input  wdata, byte_en, wdata_wide, byte_en_wide,
    output rdata, rdata_wide, busy, error
  );

  modport cpu (
    output addr, ren, wen, wen_wide,
    output wdata, byte_en, wdata_wide, byte_en_wide,
    input  rdata, rdata_wide, busy, error
  );

endinterface

// File: rtl/generic_bus_scratchpad_array.sv
// Word storage with word/block read and byte-masked word/block write.
// Ports: clk, rst, idx, we_word/wdata/be, we_block/wblock/bew, rd_word, rd_block.
module generic_bus_scratchpad_array
  import generic_bus_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [IW-1:0]                          idx,
  input  logic                                   we_word,
  input  word_t                                  wdata,
  input  logic [WORD_SIZE-1:0]                   be,
  input  logic                                   we_block,
  input  block_t                                 wblock,
  input  logic [DCACHE_BLOCK_SIZE*WORD_SIZE-1:0] bew,
  output word_t                                  rd_word,
  output block_t                                 rd_block
);

  word_t       mem [DEPTH_WORDS];
  logic [IW-1:0] base;

  assign base    = idx & ~IW'(DCACHE_BLOCK_SIZE - 1);
  assign rd_word = mem[idx];

  always_comb begin
    rd_block = '0;
    for (int w = 0; w < DCACHE_BLOCK_SIZE; w++)
      rd_block[w] = mem[base + IW'(w)];
  end

  // One register per word so each word owns its reset and lane enables.
  for (genvar i = 0; i < DEPTH_WORDS; i++) begin : g_word
    localparam int LANE = i % DCACHE_BLOCK_SIZE;
    localparam logic [IW-1:0] BLK = IW'(i - LANE);
    word_t q;
    logic  hit_w;
    logic  hit_b;

    assign hit_w  = we_word && (idx == IW'(i));
    assign hit_b  = we_block && (base == BLK);
    assign mem[i] = q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q <= '0;
      end else begin
        for (int b = 0; b < WORD_SIZE; b++) begin
          if (hit_w && be[b])
            q[8*b +: 8] <= wdata[8*b +: 8];
          else if (hit_b && bew[LANE*WORD_SIZE + b])
            q[8*b +: 8] <= wblock[LANE][8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/generic_bus_responder.sv
// Wait-state bus responder backed by a scratchpad array.
// Ports: CLK, RST, bus (generic_bus modport: requests in, rdata/busy/error out).
module generic_bus_responder
  import generic_bus_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2,
  parameter logic [RAM_ADDR_SIZE-1:0] BASE_ADDR = 32'h0000_0000
) (
  input logic                CLK,
  input logic                RST,
  generic_bus_if.generic_bus bus
);

  localparam int IW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int BE_W = DCACHE_BLOCK_SIZE * WORD_SIZE;
  localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    ERR
  } state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  op_t              op_q;
  logic             ok_q;
  logic [IW-1:0]    idx_q;
  word_t            wdata_q;
  logic [WORD_SIZE-1:0] be_q;
  block_t           wide_q;
  logic [BE_W-1:0]  bew_q;

  logic req;
  logic ok;
  op_t  op;
  logic [RAM_ADDR_SIZE-3:0] word_off;
  word_t  rd_word;
  block_t rd_block;
  logic   we_word;
  logic   we_block;

  assign req = bus.ren | bus.wen | bus.wen_wide;

  assign word_off = bus.addr[RAM_ADDR_SIZE-1:2]
                  - BASE_ADDR[RAM_ADDR_SIZE-1:2];

  assign ok = (bus.addr[1:0] == 2'b00)
           && (bus.addr >= BASE_ADDR)
           && ({2'b00, word_off} < RAM_ADDR_SIZE'(DEPTH_WORDS));

  always_comb begin
    op = OP_RD;
    if (bus.wen_wide)
      op = OP_WIDE;
    else if (bus.wen)
      op = OP_WR;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      op_q    <= OP_RD;
      ok_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      wide_q  <= '0;
      bew_q   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && req) begin
        op_q    <= op;
        ok_q    <= ok;
        idx_q   <= word_off[IW-1:0];
        wdata_q <= bus.wdata;
        be_q    <= bus.byte_en;
        wide_q  <= bus.wdata_wide;
        bew_q   <= bus.byte_en_wide;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (req) begin
          cnt_nxt = '0;
          if (WAIT_STATES == 0)
            state_nxt = ok ? RESP : ERR;
          else
            state_nxt = WAIT;
        end
      end
      WAIT: begin
        // Requester dropping every strobe mid-wait cancels the access.
        if (!req) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == WS_LAST) begin
          state_nxt = ok_q ? RESP : ERR;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy       = 1'b1;
    bus.error      = 1'b0;
    bus.rdata      = '0;
    bus.rdata_wide = '0;
    unique case (state)
      RESP: begin
        bus.busy = 1'b0;
        if (op_q == OP_RD) begin
          bus.rdata      = rd_word;
          bus.rdata_wide = rd_block;
        end
      end
      ERR: begin
        bus.busy  = 1'b0;
        bus.error = 1'b1;
      end
      default: ;
    endcase
  end

  assign we_word  = (state == RESP) && (op_q == OP_WR);
  assign we_block = (state == RESP) && (op_q == OP_WIDE);

  generic_bus_scratchpad_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IW          (IW)
  ) u_array (
    .clk      (CLK),
    .rst      (RST),
    .idx      (idx_q),
    .we_word  (we_word),
    .wdata    (wdata_q),
    .be       (be_q),
    .we_block (we_block),
    .wblock   (wide_q),
    .bew      (bew_q),
    .rd_word  (rd_word),
    .rd_block (rd_block)
  );

endmodule

// File: tb/tb_generic_bus_responder.sv
// Bench for generic_bus_responder: directed scenarios plus random
// traffic against a byte-level reference memory; a WAIT_STATES=0 copy too.
module tb_generic_bus_responder;
  import generic_bus_responder_pkg::*;

  localparam int WS    = 2;
  localparam int DEPTH = 1024;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  generic_bus_if bus ();
  generic_bus_if bus0 ();

  generic_bus_responder #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_STATES (WS),
    .BASE_ADDR   (BASE)
  ) u_dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  generic_bus_responder #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_STATES (0),
    .BASE_ADDR   (BASE)
  ) u_dut0 (
    .CLK (clk),
    .RST (rst),
    .bus (bus0)
  );

  int    n_cmp = 0;
  int    n_bad = 0;
  word_t ref_mem [DEPTH];

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a[1:0] == 2'b00) && (a >= BASE) && ((off >> 2) < 32'(DEPTH));
  endfunction

  task automatic bus_idle();
    bus.ren = 0; bus.wen = 0; bus.wen_wide = 0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  task automatic xact(input bit r, input bit w, input bit ww,
                      input logic [31:0] a, input word_t d,
                      input logic [3:0] be, input block_t dw,
                      input logic [15:0] bew);
    int     n;
    bit     ok;
    bit     rd;
    int     idx;
    int     base;
    word_t  er;
    block_t ebl;
    ok   = addr_ok(a);
    rd   = !ww && !w;
    idx  = ok ? int'((a - BASE) >> 2) : 0;
    base = idx - (idx % 4);
    er   = '0;
    ebl  = '0;
    if (ok && rd) begin
      er = ref_mem[idx];
      for (int k = 0; k < 4; k++) ebl[k] = ref_mem[base + k];
    end
    @(negedge clk);
    bus.addr = a; bus.wdata = d; bus.byte_en = be;
    bus.wdata_wide = dw; bus.byte_en_wide = bew;
    bus.ren = r; bus.wen = w; bus.wen_wide = ww;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy && n < 20);
    chk("latency", 128'(n), 128'(WS + 1));
    chk("error", 128'(bus.error), 128'(!ok));
    if (!ok || rd) begin
      chk("rdata", 128'(bus.rdata), 128'(er));
      chk("rdata_wide", bus.rdata_wide, ebl);
    end
    bus_idle();
    @(negedge clk);
    chk("one_cycle_done", 128'(bus.busy), 128'(1));
    if (ok && ww) begin
      for (int k = 0; k < 4; k++)
        for (int b = 0; b < 4; b++)
          if (bew[k*4 + b]) ref_mem[base + k][8*b +: 8] = dw[k][8*b +: 8];
    end else if (ok && w) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int     cnt;
    bit     r, w, ww;
    int     sel, widx;
    logic [31:0] a;
    block_t dw;
    logic [31:0] za [4];
    word_t  zd [4];

    clear_model();
    bus.addr = '0; bus.wdata = '0; bus.byte_en = '0;
    bus.wdata_wide = '0; bus.byte_en_wide = '0;
    bus_idle();
    bus0.addr = '0; bus0.wdata = '0; bus0.byte_en = '0;
    bus0.wdata_wide = '0; bus0.byte_en_wide = '0;
    bus0.ren = 0; bus0.wen = 0; bus0.wen_wide = 0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_busy", 128'(bus.busy), 128'(1));
    chk("rst_error", 128'(bus.error), 128'(0));
    chk("rst_rdata", 128'(bus.rdata), 128'(0));
    chk("rst_rdata_wide", bus.rdata_wide, 128'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    xact(1, 0, 0, 32'h0, '0, '0, '0, '0);
    xact(0, 1, 0, 32'h10, 32'hDEADBEEF, 4'b0101, '0, '0);
    xact(1, 0, 0, 32'h10, '0, '0, '0, '0);
    dw = {32'd4, 32'd3, 32'd2, 32'd1};
    xact(0, 0, 1, 32'h20, '0, '0, dw, 16'hFFFF);
    xact(1, 0, 0, 32'h28, '0, '0, '0, '0);
    xact(1, 0, 0, 32'h1002, '0, '0, '0, '0);
    xact(1, 0, 0, 32'h1000, '0, '0, '0, '0);

    @(negedge clk);
    bus.addr = 32'h0; bus.wdata = 32'h55; bus.byte_en = 4'hF;
    bus.wen = 1;
    @(negedge clk);
    bus_idle();
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (!bus.busy) cnt++;
    end
    chk("abort_no_completion", 128'(cnt), 128'(0));
    xact(1, 0, 0, 32'h0, '0, '0, '0, '0);

    for (int t = 0; t < 60; t++) begin
      sel  = $urandom_range(0, 9);
      widx = $urandom_range(0, 31);
      if (sel == 0)
        a = 32'(widx * 4 + $urandom_range(1, 3));
      else if (sel == 1)
        a = 32'h1000 + 32'(4 * $urandom_range(0, 255));
      else if (sel == 2)
        a = 32'hFFFF_FFF0;
      else
        a = 32'(widx * 4);
      ww = ($urandom_range(0, 3) == 0);
      w  = 1'($urandom_range(0, 1));
      r  = 1'($urandom_range(0, 1));
      if (!r && !w && !ww) r = 1;
      for (int k = 0; k < 4; k++) dw[k] = $urandom;
      xact(r, w, ww, a, $urandom, 4'($urandom_range(0, 15)), dw,
           16'($urandom_range(0, 65535)));
    end

    @(negedge clk);
    bus.addr = 32'h30; bus.wdata = 32'hA5A5A5A5; bus.byte_en = 4'hF;
    bus.wen = 1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", 128'(bus.busy), 128'(1));
    chk("rst_mid_error", 128'(bus.error), 128'(0));
    @(negedge clk);
    bus_idle();
    rst = 1'b0;
    clear_model();
    xact(1, 0, 0, 32'h30, '0, '0, '0, '0);
    xact(1, 0, 0, 32'h10, '0, '0, '0, '0);

    for (int i = 0; i < 4; i++) begin
      za[i] = 32'h40 + 32'(8 * i);
      zd[i] = $urandom;
      @(negedge clk);
      bus0.addr = za[i]; bus0.wdata = zd[i]; bus0.byte_en = 4'hF;
      bus0.wen = 1;
      @(negedge clk);
      chk("z_wr_done", 128'(bus0.busy), 128'(0));
      chk("z_wr_error", 128'(bus0.error), 128'(0));
      bus0.wen = 0;
      @(negedge clk);
      chk("z_wr_release", 128'(bus0.busy), 128'(1));
    end
    @(negedge clk);
    bus0.addr = za[0];
    bus0.ren = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k % 2 == 0) begin
        chk("z_b2b_busy", 128'(bus0.busy), 128'(0));
        chk("z_b2b_rdata", 128'(bus0.rdata), 128'(zd[k/2]));
        if (k / 2 + 1 < 4) bus0.addr = za[k/2 + 1];
      end else begin
        chk("z_b2b_busy", 128'(bus0.busy), 128'(1));
      end
    end
    bus0.ren = 0;
    @(negedge clk);
    bus0.addr = 32'h1000;
    bus0.ren = 1;
    @(negedge clk);
    chk("z_err_busy", 128'(bus0.busy), 128'(0));
    chk("z_err_error", 128'(bus0.error), 128'(1));
    chk("z_err_rdata", 128'(bus0.rdata), 128'(0));
    bus0.ren = 0;
    @(negedge clk);
    chk("z_err_release", 128'(bus0.busy), 128'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
